armsc_dmem: RTL and testbench

Data-memory responder for the single-cycle ARM core: the slave end of the core's data port, answering `MemWrite`/`ALUResult`/`WriteData` with `ReadData` in the same cycle. It holds a word-addressed RAM and a small memory-mapped I/O region with four devices:
- a free-running cycle counter;
- a transmit FIFO drained by an external ready/valid consumer;
- a sticky status/overflow register;
- a halt flag used by testbenches to end simulation.

---
 rtl/armsc_dmem_if.sv | 31 +++
 rtl/armsc_dmem.sv | 124 ++++++++++++
 tb/tb_armsc_dmem.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/armsc_dmem_if.sv
// rtl/armsc_dmem_if.sv - data-port and transmit-stream bundle between core and armsc_dmem
//
// Signals:
//   MemWrite  core -> dmem   write strobe for the current cycle
//   ALUResult core -> dmem   byte address (bits [1:0] ignored)
//   WriteData core -> dmem   store data
//   ReadData  dmem -> core   combinational load data
//   tx_data   dmem -> sink   transmit FIFO head word
//   tx_valid  dmem -> sink   transmit FIFO non-empty
//   tx_ready  sink -> dmem   consumer accepts head when high with tx_valid
//   halt      dmem -> bench  sticky halt flag
interface armsc_dmem_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;

    modport master (
        output MemWrite, ALUResult, WriteData, tx_ready,
        input  ReadData, tx_data, tx_valid, halt
    );

    modport slave (
        input  MemWrite, ALUResult, WriteData, tx_ready,
        output ReadData, tx_data, tx_valid, halt
    );
endinterface

// File: rtl/armsc_dmem.sv
// rtl/armsc_dmem.sv - single-cycle core data memory with RAM and memory-mapped I/O
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous active-high reset (RAM contents are retained)
//   bus    armsc_dmem_if.slave: core data port plus transmit stream and halt
//
// Address map (full 32-bit decode):
//   0x0000_0000 .. RAM_WORDS*4-1  RAM
//   0x8000_0000 TXDATA  write pushes, read returns FIFO count
//   0x8000_0004 STATUS  {count[7:0] at [15:8], overflow, full, empty}; write clears overflow
//   0x8000_0008 CYCLE   free-running counter; write loads it
//   0x8000_000C HALT    read {31'b0, halt}; write sets halt
//   anything else reads 0, writes ignored
module armsc_dmem #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    armsc_dmem_if.slave  bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0] RAM_BYTES   = 32'(RAM_WORDS * 4);
    localparam logic [31:0] ADDR_TX     = 32'h8000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
    localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0008;
    localparam logic [31:0] ADDR_HALT   = 32'h8000_000C;

    logic [31:0]   ram      [RAM_WORDS];
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          overflow;
    logic          halt_q;
    logic [31:0]   cycle_cnt;

    logic          sel_ram;
    logic          sel_tx;
    logic          sel_status;
    logic          sel_cycle;
    logic          sel_halt;
    logic [AW-1:0] ram_idx;
    logic          empty;
    logic          full;
    logic          pop;
    logic          tx_write;
    logic          push;
    logic          drop;
    logic [31:0]   count_ext;
    logic [31:0]   status_word;

    assign sel_ram    = (bus.ALUResult < RAM_BYTES);
    assign sel_tx     = (bus.ALUResult == ADDR_TX);
    assign sel_status = (bus.ALUResult == ADDR_STATUS);
    assign sel_cycle  = (bus.ALUResult == ADDR_CYCLE);
    assign sel_halt   = (bus.ALUResult == ADDR_HALT);
    assign ram_idx    = bus.ALUResult[AW+1:2];

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign pop   = !empty && bus.tx_ready;

    // A push into a full FIFO still succeeds when the head leaves in the
    // same cycle; otherwise the word is dropped and flagged.
    assign tx_write = bus.MemWrite && sel_tx;
    assign push     = tx_write && (!full || pop);
    assign drop     = tx_write && full && !pop;

    assign count_ext   = 32'(count);
    assign status_word = {16'h0000, count_ext[7:0], 5'b00000, overflow, full, empty};

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = fifo_mem[head];
    assign bus.halt     = halt_q;

    always_comb begin
        bus.ReadData = 32'h0;
        if (sel_ram)         bus.ReadData = ram[ram_idx];
        else if (sel_tx)     bus.ReadData = count_ext;
        else if (sel_status) bus.ReadData = status_word;
        else if (sel_cycle)  bus.ReadData = cycle_cnt;
        else if (sel_halt)   bus.ReadData = {31'h0, halt_q};
    end

    // Storage arrays carry no reset; reset only blocks writes.
    always_ff @(posedge clk) begin
        if (!reset && bus.MemWrite && sel_ram) begin
            ram[ram_idx] <= bus.WriteData;
        end
        if (!reset && push) begin
            fifo_mem[tail] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            halt_q    <= 1'b0;
            cycle_cnt <= 32'h0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);

            if (bus.MemWrite && sel_status) overflow <= 1'b0;
            else if (drop)                  overflow <= 1'b1;

            if (bus.MemWrite && sel_halt) halt_q <= 1'b1;

            // A load replaces the increment for that cycle.
            if (bus.MemWrite && sel_cycle) cycle_cnt <= bus.WriteData;
            else                           cycle_cnt <= cycle_cnt + 32'h1;
        end
    end
endmodule

// File: tb/tb_armsc_dmem.sv
// tb/tb_armsc_dmem.sv - self-checking bench for armsc_dmem with behavioural model
module tb_armsc_dmem;
    localparam int RAM_WORDS  = 64;
    localparam int FIFO_DEPTH = 8;

    localparam logic [31:0] A_TX     = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
    localparam logic [31:0] A_HALT   = 32'h8000_000C;
    localparam logic [31:0] A_UNMAP  = 32'h4000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    armsc_dmem_if bus ();

    armsc_dmem #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [31:0] m_ram   [RAM_WORDS];
    bit          m_ram_v [RAM_WORDS];
    logic [31:0] m_q     [$];
    bit          m_ovf;
    bit          m_halt;
    logic [31:0] m_cyc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
        int n;
        n = m_q.size();
        v = 32'h0;
        if (a < RAM_WORDS * 4) begin
            if (!m_ram_v[a / 4]) return 1'b0;
            v = m_ram[a / 4];
        end else if (a == A_TX) begin
            v = n;
        end else if (a == A_STATUS) begin
            v = (n << 8) | (m_ovf ? 4 : 0) | ((n == FIFO_DEPTH) ? 2 : 0) | ((n == 0) ? 1 : 0);
        end else if (a == A_CYCLE) begin
            v = m_cyc;
        end else if (a == A_HALT) begin
            v = {31'h0, m_halt};
        end
        return 1'b1;
    endfunction

    // Model advance at the clock edge, from inputs only
    always @(posedge clk) begin
        bit pop, wr_tx, accept;
        logic [31:0] a, d;
        a = bus.ALUResult;
        d = bus.WriteData;
        if (reset) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_halt = 1'b0;
            m_cyc  = 32'h0;
        end else begin
            pop    = (m_q.size() > 0) && bus.tx_ready;
            wr_tx  = bus.MemWrite && (a == A_TX);
            accept = wr_tx && ((m_q.size() < FIFO_DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (accept) m_q.push_back(d);
            if (wr_tx && !accept) m_ovf = 1'b1;
            if (bus.MemWrite && a == A_STATUS) m_ovf = 1'b0;
            if (bus.MemWrite && a == A_HALT) m_halt = 1'b1;
            if (bus.MemWrite && a == A_CYCLE) m_cyc = d;
            else m_cyc = m_cyc + 1;
            if (bus.MemWrite && a < RAM_WORDS * 4) begin
                m_ram[a / 4]   = d;
                m_ram_v[a / 4] = 1'b1;
            end
        end
    end

    // Compare process: every cycle, mid-period
    always @(negedge clk) begin
        logic [31:0] exp;
        if (chk_en) begin
            if (model_read(bus.ALUResult, exp)) check("model_rdata", bus.ReadData, exp);
            check("model_tx_valid", {31'h0, bus.tx_valid}, (m_q.size() != 0) ? 32'h1 : 32'h0);
            if (m_q.size() != 0) check("model_tx_data", bus.tx_data, m_q[0]);
            check("model_halt", {31'h0, bus.halt}, {31'h0, m_halt});
        end
    end

    task automatic drive(input logic rst, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.MemWrite  = we;
        bus.ALUResult = a;
        bus.WriteData = d;
        bus.tx_ready  = rdy;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic rdy,
                            input logic [31:0] exp);
        drive(1'b0, 1'b0, a, 32'h0, rdy);
        #1;
        check(name, bus.ReadData, exp);
    endtask

    initial begin
        logic [31:0] a;
        int sel;
        for (int i = 0; i < RAM_WORDS; i++) m_ram_v[i] = 1'b0;
        reset         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.ALUResult = 32'h0;
        bus.WriteData = 32'h0;
        bus.tx_ready  = 1'b0;
        drive(1'b1, 1'b0, A_UNMAP, 32'h0, 1'b0);
        drive(1'b1, 1'b0, A_UNMAP, 32'h0, 1'b0);
        chk_en = 1'b1;

        // Reset state
        rd_check("rst_cycle", A_CYCLE, 1'b0, 32'h0);
        check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("rst_halt", {31'h0, bus.halt}, 32'h0);
        rd_check("rst_status", A_STATUS, 1'b0, 32'h0000_0001);
        rd_check("rst_txdata", A_TX, 1'b0, 32'h0);

        // RAM
        drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        drive(1'b0, 1'b1, 32'h14, 32'h1234_5678, 1'b0);
        rd_check("ram_10", 32'h10, 1'b0, 32'hDEAD_BEEF);
        rd_check("ram_13", 32'h13, 1'b0, 32'hDEAD_BEEF);
        rd_check("ram_14", 32'h14, 1'b0, 32'h1234_5678);
        drive(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
        #1 check("ram_same_cycle_old", bus.ReadData, 32'hDEAD_BEEF);
        rd_check("ram_10_new", 32'h10, 1'b0, 32'h0);

        // FIFO ordering
        for (int i = 1; i <= 3; i++) drive(1'b0, 1'b1, A_TX, 32'(i), 1'b0);
        rd_check("fifo3_status", A_STATUS, 1'b0, 32'h0000_0300);
        for (int i = 1; i <= 3; i++) begin
            rd_check("fifo_drain_status", A_STATUS, 1'b1, 32'((4 - i) << 8));
            check("fifo_drain_data", bus.tx_data, 32'(i));
        end
        rd_check("fifo_empty_status", A_STATUS, 1'b0, 32'h0000_0001);
        check("fifo_empty_valid", {31'h0, bus.tx_valid}, 32'h0);

        // Overflow
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, A_TX, 32'(100 + i), 1'b0);
        rd_check("ovf_status", A_STATUS, 1'b0, 32'h0000_0806);
        drive(1'b0, 1'b1, A_TX, 32'd200, 1'b1);
        #1 check("full_pushpop_head", bus.tx_data, 32'd100);
        rd_check("full_pushpop_status", A_STATUS, 1'b0, 32'h0000_0806);
        check("full_pushpop_next", bus.tx_data, 32'd101);
        drive(1'b0, 1'b1, A_STATUS, 32'h0, 1'b0);
        rd_check("ovf_cleared", A_STATUS, 1'b0, 32'h0000_0802);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, A_UNMAP, 32'h0, 1'b1);
        rd_check("drained", A_STATUS, 1'b0, 32'h0000_0001);

        // Cycle counter wrap
        drive(1'b0, 1'b1, A_CYCLE, 32'hFFFF_FFFE, 1'b0);
        rd_check("cyc_load", A_CYCLE, 1'b0, 32'hFFFF_FFFE);
        rd_check("cyc_inc", A_CYCLE, 1'b0, 32'hFFFF_FFFF);
        rd_check("cyc_wrap", A_CYCLE, 1'b0, 32'h0000_0000);

        // Halt and unmapped
        drive(1'b0, 1'b1, A_HALT, 32'h0, 1'b0);
        rd_check("halt_read", A_HALT, 1'b0, 32'h1);
        check("halt_set", {31'h0, bus.halt}, 32'h1);
        rd_check("unmap_read", A_UNMAP, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 1'b0);
        rd_check("unmap_no_effect", A_STATUS, 1'b0, 32'h0000_0001);
        check("halt_persists", {31'h0, bus.halt}, 32'h1);

        // Reset mid-operation
        drive(1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5, 1'b0);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, A_TX, 32'(300 + i), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, A_UNMAP, 32'h0, 1'b1);
        drive(1'b1, 1'b1, A_TX, 32'h5555_5555, 1'b1);
        rd_check("rst_mid_status", A_STATUS, 1'b0, 32'h0000_0001);
        check("rst_mid_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("rst_mid_halt", {31'h0, bus.halt}, 32'h0);
        rd_check("rst_mid_ram", 32'h0, 1'b0, 32'hA5A5_A5A5);

        // Randomized traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: a = $urandom_range(0, RAM_WORDS * 4 - 1);
                3, 4:    a = A_TX;
                5:       a = A_STATUS;
                6:       a = A_CYCLE;
                7:       a = ($urandom_range(0, 15) == 0) ? A_HALT : A_UNMAP;
                8:       a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
                default: a = $urandom;
            endcase
            drive(($urandom_range(0, 199) == 0), $urandom_range(0, 1), a, $urandom,
                  ($urandom_range(0, 2) == 0));
        end
        drive(1'b0, 1'b0, A_UNMAP, 32'h0, 1'b0);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
